// File: rtl/uart_program_loader.sv
// ============================================================================
// Module   : uart_program_loader
// Purpose  : 8N1 serial boot loader. It writes a word-count-prefixed program
//            image into instruction memory and holds the core in reset until
//            the whole image has been written.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_program_loader #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned            c_clks_per_bit = CLK_FREQ / BAUD;
  localparam int unsigned            c_tmr_w        = $clog2(c_clks_per_bit + 1);
  localparam logic [c_tmr_w-1:0]     c_bit_last     = c_tmr_w'(c_clks_per_bit - 1);
  localparam logic [c_tmr_w-1:0]     c_half_last    = c_tmr_w'(c_clks_per_bit / 2 - 1);
  localparam logic [16:0]            c_max_words    = 17'(1 << ADDR_WIDTH);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    L_SYNC   = 3'd0,
    L_CNT_LO = 3'd1,
    L_CNT_HI = 3'd2,
    L_DATA   = 3'd3,
    L_DONE   = 3'd4,
    L_ERR    = 3'd5
  } ld_state_t;

  logic                  r_rx_meta;
  logic                  r_rxs;
  rx_state_t             r_rx_state;
  logic [c_tmr_w-1:0]    r_tmr;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic                  r_byte_valid;
  logic                  r_frame_err;

  ld_state_t             r_ld_state;
  logic [7:0]            r_cnt_lo;
  logic [15:0]           r_count;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [1:0]            r_byte_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wd;
  logic                  r_core_rst_n;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic [15:0]           w_count;
  logic                  w_last_word;

  // The byte register stays stable from byte_valid until the next byte's data bits.
  assign w_count     = {r_shift, r_cnt_lo};
  assign w_last_word = ({{(16 - ADDR_WIDTH){1'b0}}, r_word_idx} == (r_count - 16'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state   <= RX_IDLE;
      r_tmr        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rxs) begin
            r_rx_state <= RX_START;
            r_tmr      <= '0;
          end
        end
        RX_START: begin
          if (r_tmr == c_half_last) begin
            r_tmr      <= '0;
            r_bit_idx  <= '0;
            r_rx_state <= r_rxs ? RX_IDLE : RX_DATA;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_tmr == c_bit_last) begin
            r_tmr     <= '0;
            r_shift   <= {r_rxs, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_tmr == c_bit_last) begin
            r_tmr        <= '0;
            r_byte_valid <= r_rxs;
            r_frame_err  <= ~r_rxs;
            r_rx_state   <= RX_IDLE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ld_state   <= L_SYNC;
      r_cnt_lo     <= '0;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wd     <= '0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_ld_state)
        L_SYNC: begin
          if (r_byte_valid && (r_shift == 8'hA5)) begin
            r_busy     <= 1'b1;
            r_ld_state <= L_CNT_LO;
          end
        end
        L_CNT_LO: begin
          if (r_frame_err) begin
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_ld_state <= L_ERR;
          end else if (r_byte_valid) begin
            r_cnt_lo   <= r_shift;
            r_ld_state <= L_CNT_HI;
          end
        end
        L_CNT_HI: begin
          if (r_frame_err) begin
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_ld_state <= L_ERR;
          end else if (r_byte_valid) begin
            r_count    <= w_count;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            if (w_count == 16'd0) begin
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_core_rst_n <= 1'b1;
              r_ld_state   <= L_DONE;
            end else if ({1'b0, w_count} > c_max_words) begin
              r_error    <= 1'b1;
              r_busy     <= 1'b0;
              r_ld_state <= L_ERR;
            end else begin
              r_ld_state <= L_DATA;
            end
          end
        end
        L_DATA: begin
          if (r_frame_err) begin
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_ld_state <= L_ERR;
          end else if (r_mem_we) begin
            // Strobe cycle: decide completion so done rises right after the last write.
            if (w_last_word) begin
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_core_rst_n <= 1'b1;
              r_ld_state   <= L_DONE;
            end else begin
              r_word_idx <= r_word_idx + 1'b1;
            end
          end else if (r_byte_valid) begin
            r_word[{r_byte_idx, 3'b000} +: 8] <= r_shift;
            r_byte_idx                        <= r_byte_idx + 1'b1;
            if (r_byte_idx == 2'd3) begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= r_word_idx;
              r_mem_wd   <= {r_shift, r_word[DATA_WIDTH-9:0]};
            end
          end
        end
        L_DONE:  r_ld_state <= L_DONE;
        L_ERR:   r_ld_state <= L_ERR;
        default: r_ld_state <= L_ERR;
      endcase
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wd     = r_mem_wd;
  assign core_rst_n = r_core_rst_n;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_uart_program_loader.sv
// ============================================================================
// Module   : tb_uart_program_loader
// Purpose  : Self-checking bench for uart_program_loader (table, random, corner
//            sequences) against a byte-stream reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_program_loader;

  localparam int CPB = 10;
  localparam int AW  = 6;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLK_FREQ  (1000000),
    .BAUD      (100000),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor
  logic [AW+DW-1:0] wr_q[$];
  int               cyc = 0;
  int               last_we_cyc = -1;
  int               done_cyc = -1;
  int               run = 0;
  int               max_run = 0;
  logic             prev_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      wr_q.push_back({mem_addr, mem_wd});
      last_we_cyc = cyc;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
    prev_done = done;
  end

  task automatic clear_mon();
    wr_q.delete();
    max_run     = 0;
    last_we_cyc = -1;
    done_cyc    = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (good_stop ? CPB : 3 * CPB) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_we"},     32'(mem_we),     32'd0);
    check({tag, " mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, " mem_wd"},     mem_wd,          32'd0);
    check({tag, " core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, " busy"},       32'(busy),       32'd0);
    check({tag, " done"},       32'(done),       32'd0);
    check({tag, " error"},      32'(error),      32'd0);
  endtask

  // Stimulus stream and expected results
  logic [7:0]       stim_b[$];
  bit               stim_bad[$];
  logic [AW+DW-1:0] exp_q[$];
  bit               exp_done;
  bit               exp_err;

  // Byte-level reference: locate the sync, read the count, then slice whole words.
  function automatic void model();
    int s;
    int n;
    logic [31:0] w;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    s = -1;
    for (int i = 0; i < stim_b.size(); i++)
      if (!stim_bad[i] && stim_b[i] == 8'hA5) begin
        s = i;
        break;
      end
    if (s < 0) return;
    for (int k = 1; k <= 2; k++) begin
      if (s + k >= stim_b.size()) return;
      if (stim_bad[s + k]) begin
        exp_err = 1'b1;
        return;
      end
    end
    n = int'(stim_b[s + 1]) + 256 * int'(stim_b[s + 2]);
    if (n == 0) begin
      exp_done = 1'b1;
      return;
    end
    if (n > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    for (int wi = 0; wi < n; wi++) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = s + 3 + 4 * wi + k;
        if (idx >= stim_b.size()) return;
        if (stim_bad[idx]) begin
          exp_err = 1'b1;
          return;
        end
        w[8*k +: 8] = stim_b[idx];
      end
      exp_q.push_back({AW'(wi), w});
    end
    exp_done = 1'b1;
  endfunction

  task automatic run_scenario(input string tag, input bit do_reset);
    int nchk;
    if (do_reset) apply_reset();
    for (int i = 0; i < stim_b.size(); i++) send_byte(stim_b[i], !stim_bad[i]);
    repeat (30) @(negedge clk);
    check({tag, " writes"}, 32'(wr_q.size()), 32'(exp_q.size()));
    nchk = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s addr%0d", tag, i), 32'(wr_q[i][AW+DW-1:DW]), 32'(exp_q[i][AW+DW-1:DW]));
      check($sformatf("%s data%0d", tag, i), wr_q[i][DW-1:0], exp_q[i][DW-1:0]);
    end
    check({tag, " strobe_width"}, 32'(max_run), (exp_q.size() > 0) ? 32'd1 : 32'd0);
    check({tag, " done"},         32'(done),       32'(exp_done));
    check({tag, " error"},        32'(error),      32'(exp_err));
    check({tag, " core_rst_n"},   32'(core_rst_n), 32'(exp_done));
    check({tag, " busy"},         32'(busy),       32'(!(exp_done || exp_err)));
  endtask

  typedef struct {
    string       name;
    int          nb;
    logic [95:0] b;      // byte 0 in the top octet
    int          bad_idx;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          e_done;
    bit          e_err;
  } vec_t;

  task automatic load_stim(input vec_t v);
    stim_b.delete();
    stim_bad.delete();
    for (int i = 0; i < v.nb; i++) begin
      stim_b.push_back(v.b[95 - 8*i -: 8]);
      stim_bad.push_back(i == v.bad_idx);
    end
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{"normal",   11, 96'hA502001305A0009305100000, -1, 2, 32'h00A00513, 32'h00100593, 1'b1, 1'b0};
    tbl[1] = '{"noise",     9, 96'hFF3CA50100DEADBEEF000000, -1, 1, 32'hEFBEADDE, 32'h0,        1'b1, 1'b0};
    tbl[2] = '{"zero",      3, 96'hA50000000000000000000000, -1, 0, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[3] = '{"oversize",  7, 96'hA54100112233440000000000, -1, 0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[4] = '{"framing",  11, 96'hA502001305A0009305100000,  4, 0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[5] = '{"max64",     7, 96'hA54000010203040000000000, -1, 1, 32'h04030201, 32'h0,        1'b0, 1'b0};
    tbl[6] = '{"badsync",   8, 96'hA5A5010011223344_00000000, 0, 1, 32'h44332211, 32'h0,        1'b1, 1'b0};

    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("post_reset");

    // Table vectors
    foreach (tbl[t]) begin
      load_stim(tbl[t]);
      exp_q.delete();
      if (tbl[t].nw > 0) exp_q.push_back({AW'(0), tbl[t].w0});
      if (tbl[t].nw > 1) exp_q.push_back({AW'(1), tbl[t].w1});
      exp_done = tbl[t].e_done;
      exp_err  = tbl[t].e_err;
      run_scenario(tbl[t].name, 1'b1);
    end

    // Busy window and done timing on the normal image
    load_stim(tbl[0]);
    apply_reset();
    send_byte(stim_b[0], 1'b1);
    check("timing busy_after_sync", 32'(busy), 32'd1);
    for (int i = 1; i < 10; i++) send_byte(stim_b[i], 1'b1);
    check("timing busy_mid", 32'(busy), 32'd1);
    check("timing done_mid", 32'(done), 32'd0);
    send_byte(stim_b[10], 1'b1);
    repeat (30) @(negedge clk);
    check("timing writes", 32'(wr_q.size()), 32'd2);
    check("timing done_after_strobe", 32'(done_cyc - last_we_cyc), 32'd1);

    // Short low glitch while waiting for the count must not yield a byte
    apply_reset();
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch error", 32'(error), 32'd0);
    stim_b   = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    stim_bad = '{0, 0, 0, 0, 0, 0};
    exp_q.delete();
    exp_q.push_back({AW'(0), 32'h44332211});
    exp_done = 1'b1;
    exp_err  = 1'b0;
    run_scenario("glitch", 1'b0);

    // Reset mid-load, then a fresh image from address 0
    apply_reset();
    stim_b   = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    stim_bad = '{0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < stim_b.size(); i++) send_byte(stim_b[i], 1'b1);
    begin
      int waited;
      waited = 0;
      while (wr_q.size() == 0 && waited < 500) begin
        @(negedge clk);
        waited++;
      end
      check("midreset first_write_seen", 32'(wr_q.size() > 0), 32'd1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    clear_mon();
    load_stim(tbl[0]);
    model();
    run_scenario("midreset reload", 1'b0);

    // Randomized images against the reference model
    for (int r = 0; r < 12; r++) begin
      int npre;
      int sel;
      int n;
      int ndata;
      logic [7:0] b;
      stim_b.delete();
      stim_bad.delete();
      npre = $urandom_range(0, 2);
      for (int i = 0; i < npre; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        stim_b.push_back(b);
        stim_bad.push_back($urandom_range(0, 3) == 0);
      end
      stim_b.push_back(8'hA5);
      stim_bad.push_back(1'b0);
      sel = $urandom_range(0, 9);
      n = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(65, 300) : $urandom_range(1, 3);
      stim_b.push_back(8'(n));
      stim_bad.push_back(1'b0);
      stim_b.push_back(8'(n >> 8));
      stim_bad.push_back(1'b0);
      ndata = (n >= 1 && n <= 3) ? 4 * n : 4;
      for (int i = 0; i < ndata; i++) begin
        stim_b.push_back(8'($urandom_range(0, 255)));
        stim_bad.push_back(1'b0);
      end
      if ($urandom_range(0, 4) == 0)
        stim_bad[$urandom_range(npre + 1, stim_b.size() - 1)] = 1'b1;
      model();
      run_scenario($sformatf("rand%0d", r), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
